sram_axi_bridge: RTL and testbench



---
 rtl/sram_axi_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Purpose : bridges the core's inst/data SRAM-like ports onto one single-beat AXI3 master.
// Latency : request-to-data_ok minimum 2 cycles (addr_ok at T, AR/AW/W at T+1, R/B at T+2).
// Backpr. : addr_ok withheld while the owning FSM is busy; AR/AW/W hold payload until ready.
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   inst_sram_*                   : instruction fetch port (read only)
//   data_sram_*                   : data port (read or write, one outstanding at a time)
//   ar*/r*                        : AXI read address / read data channels
//   aw*/w*/b*                     : AXI write address / write data / write response channels
module sram_axi_bridge #(
   parameter logic [3:0] ID_INST = 4'd0,
   parameter logic [3:0] ID_DATA = 4'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

   rstate_t     r_rstate, w_rnext;
   wstate_t     r_wstate, w_wnext;
   logic [3:0]  r_arid;
   logic [31:0] r_araddr;
   logic [2:0]  r_arsize;
   logic        r_rd_is_data;   // read FSM currently owned by the data port
   logic [31:0] r_awaddr;
   logic [2:0]  r_awsize;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic        r_aw_done;
   logic        r_w_done;

   logic        w_rd_acc;
   logic        w_inst_acc;
   logic        w_wr_acc;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_rd_data_busy;

   // A data read in flight blocks data writes so loads and stores stay ordered.
   assign w_rd_data_busy = (r_rstate != R_IDLE) && r_rd_is_data;

   // Read FSM: state register
   always_ff @(posedge clk) begin
      if (reset) r_rstate <= R_IDLE;
      else       r_rstate <= w_rnext;
   end

   // Read FSM: arbitration, next state and channel outputs
   always_comb begin
      w_rnext    = r_rstate;
      w_rd_acc   = 1'b0;
      w_inst_acc = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            // Data read has priority, but only when no store is outstanding.
            if (data_sram_req && !data_sram_wr && (r_wstate == W_IDLE)) w_rd_acc = 1'b1;
            else if (inst_sram_req)                                       w_inst_acc = 1'b1;
            if (w_rd_acc || w_inst_acc) w_rnext = R_ADDR;
         end
         R_ADDR: begin
            arvalid = 1'b1;
            if (arready) w_rnext = R_DATA;
         end
         R_DATA: begin
            rready = 1'b1;
            if (rvalid) w_rnext = R_IDLE;
         end
         default: w_rnext = R_IDLE;
      endcase
   end

   // Write FSM: state register
   always_ff @(posedge clk) begin
      if (reset) r_wstate <= W_IDLE;
      else       r_wstate <= w_wnext;
   end

   // Write FSM: acceptance, next state and channel outputs
   always_comb begin
      w_wnext  = r_wstate;
      w_wr_acc = 1'b0;
      w_aw_hs  = 1'b0;
      w_w_hs   = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      bready   = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (data_sram_req && data_sram_wr && !w_rd_data_busy) begin
               w_wr_acc = 1'b1;
               w_wnext  = W_SEND;
            end
         end
         W_SEND: begin
            awvalid = !r_aw_done;
            wvalid  = !r_w_done;
            w_aw_hs = awvalid && awready;
            w_w_hs  = wvalid && wready;
            // AW and W may finish in either order or together.
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_wnext = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) w_wnext = W_IDLE;
         end
         default: w_wnext = W_IDLE;
      endcase
   end

   // Latched request payloads and AW/W completion flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_arid       <= 4'd0;
         r_araddr     <= 32'd0;
         r_arsize     <= 3'd0;
         r_rd_is_data <= 1'b0;
         r_awaddr     <= 32'd0;
         r_awsize     <= 3'd0;
         r_wstrb      <= 4'd0;
         r_wdata      <= 32'd0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
      end else begin
         if (w_rd_acc) begin
            r_arid       <= ID_DATA;
            r_araddr     <= data_sram_addr;
            r_arsize     <= {1'b0, data_sram_size};
            r_rd_is_data <= 1'b1;
         end else if (w_inst_acc) begin
            r_arid       <= ID_INST;
            r_araddr     <= inst_sram_addr;
            r_arsize     <= 3'd2;
            r_rd_is_data <= 1'b0;
         end
         if (w_wr_acc) begin
            r_awaddr  <= data_sram_addr;
            r_awsize  <= {1'b0, data_sram_size};
            r_wstrb   <= data_sram_wstrb;
            r_wdata   <= data_sram_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
         end
      end
   end

   assign arid   = r_arid;
   assign araddr = r_araddr;
   assign arsize = r_arsize;
   assign awaddr = r_awaddr;
   assign awsize = r_awsize;
   assign wstrb  = r_wstrb;
   assign wdata  = r_wdata;

   assign inst_sram_addr_ok = w_inst_acc;
   assign data_sram_addr_ok = w_rd_acc || w_wr_acc;

   // Read responses are routed by rid; data read and data write are never
   // outstanding together, so the two data_ok sources cannot collide.
   assign inst_sram_data_ok = (r_rstate == R_DATA) && rvalid && (rid == ID_INST);
   assign data_sram_data_ok = ((r_rstate == R_DATA) && rvalid && (rid == ID_DATA)) ||
                              ((r_wstate == W_RESP) && bvalid);
   assign inst_sram_rdata   = rdata;
   assign data_sram_rdata   = rdata;

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid, rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic        bvalid, bready;

   always #5 clk = ~clk;

   sram_axi_bridge #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   int checks = 0;
   int errors = 0;

   // Handshake bits, MSB first:
   // inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready
   function automatic logic [8:0] get_ctl();
      return {inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok,
              arvalid, rready, awvalid, wvalid, bready};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cy(input string nm, input logic [8:0] exp);
      #1;
      chk(nm, 64'(get_ctl()), 64'(exp));
   endtask

   task automatic nx();
      @(negedge clk);
   endtask

   task automatic clr();
      inst_sram_req = 0; inst_sram_addr = 0;
      data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
      data_sram_addr = 0; data_sram_wdata = 0;
      arready = 0; rid = 0; rdata = 0; rvalid = 0;
      awready = 0; wready = 0; bvalid = 0;
   endtask

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic [1:0]  dsize;
      logic [31:0] daddr;
      logic        arrdy;
      logic [3:0]  rid;
      logic [31:0] rdata;
      logic        rvld;
      logic [8:0]  ctl;
      logic [3:0]  e_arid;
      logic [31:0] e_araddr;
      logic [2:0]  e_arsize;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[16];

   initial begin
      // Read-side vectors (data_sram_wr held 0)
      // Reset state
      vecs[0]  = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd0, 32'h0,        0, 9'b000000000, 4'd0, 32'h0,        3'd0, 32'h0};
      // Single instruction read, zero wait states
      vecs[1]  = '{1, 32'h1C000000, 0, 2'd0, 32'h0,   0, 4'd0, 32'h0,        0, 9'b100000000, 4'd0, 32'h0,        3'd0, 32'h0};
      vecs[2]  = '{0, 32'h0,        0, 2'd0, 32'h0,   1, 4'd0, 32'h0,        0, 9'b000010000, 4'd0, 32'h1C000000, 3'd2, 32'h0};
      vecs[3]  = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd0, 32'h02800C0C, 1, 9'b010001000, 4'd0, 32'h1C000000, 3'd2, 32'h02800C0C};
      vecs[4]  = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd0, 32'h0,        0, 9'b000000000, 4'd0, 32'h1C000000, 3'd2, 32'h0};
      // Simultaneous inst + data read: data wins, inst accepted after data_ok
      vecs[5]  = '{1, 32'h1C000004, 1, 2'd2, 32'h200, 0, 4'd0, 32'h0,        0, 9'b001000000, 4'd0, 32'h1C000000, 3'd2, 32'h0};
      vecs[6]  = '{1, 32'h1C000004, 0, 2'd0, 32'h0,   1, 4'd0, 32'h0,        0, 9'b000010000, 4'd1, 32'h200,      3'd2, 32'h0};
      vecs[7]  = '{1, 32'h1C000004, 0, 2'd0, 32'h0,   0, 4'd1, 32'hDEADBEEF, 1, 9'b000101000, 4'd1, 32'h200,      3'd2, 32'hDEADBEEF};
      vecs[8]  = '{1, 32'h1C000004, 0, 2'd0, 32'h0,   0, 4'd0, 32'h0,        0, 9'b100000000, 4'd1, 32'h200,      3'd2, 32'h0};
      vecs[9]  = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd0, 32'h0,        0, 9'b000010000, 4'd0, 32'h1C000004, 3'd2, 32'h0};
      vecs[10] = '{0, 32'h0,        0, 2'd0, 32'h0,   1, 4'd0, 32'h0,        0, 9'b000010000, 4'd0, 32'h1C000004, 3'd2, 32'h0};
      vecs[11] = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd0, 32'h12345678, 1, 9'b010001000, 4'd0, 32'h1C000004, 3'd2, 32'h12345678};
      // Halfword data read: arsize = {0,size}
      vecs[12] = '{0, 32'h0,        1, 2'd1, 32'h202, 0, 4'd0, 32'h0,        0, 9'b001000000, 4'd0, 32'h1C000004, 3'd2, 32'h0};
      vecs[13] = '{0, 32'h0,        0, 2'd0, 32'h0,   1, 4'd0, 32'h0,        0, 9'b000010000, 4'd1, 32'h202,      3'd1, 32'h0};
      vecs[14] = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd1, 32'h0000BEEF, 1, 9'b000101000, 4'd1, 32'h202,      3'd1, 32'h0000BEEF};
      vecs[15] = '{0, 32'h0,        0, 2'd0, 32'h0,   0, 4'd0, 32'h0,        0, 9'b000000000, 4'd1, 32'h202,      3'd1, 32'h0};

      clr();
      reset = 1;
      repeat (2) nx();
      reset = 0;

      for (int i = 0; i < 16; i++) begin
         clr();
         inst_sram_req  = vecs[i].ireq;
         inst_sram_addr = vecs[i].iaddr;
         data_sram_req  = vecs[i].dreq;
         data_sram_size = vecs[i].dsize;
         data_sram_addr = vecs[i].daddr;
         arready        = vecs[i].arrdy;
         rid            = vecs[i].rid;
         rdata          = vecs[i].rdata;
         rvalid         = vecs[i].rvld;
         cy($sformatf("vec%0d_ctl", i), vecs[i].ctl);
         chk($sformatf("vec%0d_ar", i), 64'({arid, araddr, arsize}),
             64'({vecs[i].e_arid, vecs[i].e_araddr, vecs[i].e_arsize}));
         if (vecs[i].ctl[7]) chk($sformatf("vec%0d_irdata", i), 64'(inst_sram_rdata), 64'(vecs[i].e_rdata));
         if (vecs[i].ctl[5]) chk($sformatf("vec%0d_drdata", i), 64'(data_sram_rdata), 64'(vecs[i].e_rdata));
         nx();
      end

      // Byte store, awready delayed 3 cycles, wready immediate
      clr(); data_sram_req = 1; data_sram_wr = 1; data_sram_size = 0; data_sram_wstrb = 4'b1000;
      data_sram_addr = 32'h103; data_sram_wdata = 32'hAA000000;
      cy("st_accept", 9'b001000000); nx();
      clr(); wready = 1;
      cy("st_send1", 9'b000000110);
      chk("st_aw_payload", 64'({awaddr, awsize}), 64'({32'h103, 3'd0}));
      chk("st_w_payload", 64'({wdata, wstrb}), 64'({32'hAA000000, 4'b1000}));
      nx();
      clr(); cy("st_send2", 9'b000000100); nx();
      clr(); awready = 1; cy("st_send3", 9'b000000100); nx();
      clr(); bvalid = 1; cy("st_resp", 9'b000100001); nx();
      clr(); cy("st_idle", 9'b000000000); nx();

      // Load held off while a store waits 5 cycles for bvalid
      clr(); data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2; data_sram_wstrb = 4'hF;
      data_sram_addr = 32'h300; data_sram_wdata = 32'h55667788;
      cy("ld_st_accept", 9'b001000000); nx();
      clr(); awready = 1; wready = 1; cy("ld_st_send", 9'b000000110); nx();
      for (int k = 0; k < 5; k++) begin
         clr(); data_sram_req = 1; data_sram_size = 2; data_sram_addr = 32'h300;
         cy($sformatf("ld_blocked%0d", k), 9'b000000001); nx();
      end
      clr(); data_sram_req = 1; data_sram_size = 2; data_sram_addr = 32'h300; bvalid = 1;
      cy("ld_st_done", 9'b000100001); nx();
      clr(); data_sram_req = 1; data_sram_size = 2; data_sram_addr = 32'h300;
      cy("ld_accept", 9'b001000000); nx();
      clr(); arready = 1; cy("ld_ar", 9'b000010000);
      chk("ld_ar_payload", 64'({arid, araddr, arsize}), 64'({4'd1, 32'h300, 3'd2})); nx();
      clr(); rvalid = 1; rid = 1; rdata = 32'h55667788; cy("ld_r", 9'b000101000);
      chk("ld_rdata", 64'(data_sram_rdata), 64'(32'h55667788)); nx();

      // Instruction read in flight with a concurrent store
      clr(); inst_sram_req = 1; inst_sram_addr = 32'h1C000010; cy("cc_iacc", 9'b100000000); nx();
      clr(); data_sram_req = 1; data_sram_wr = 1; data_sram_size = 1; data_sram_wstrb = 4'b0011;
      data_sram_addr = 32'h400; data_sram_wdata = 32'h0000ABCD;
      cy("cc_wacc", 9'b001010000); nx();
      clr(); arready = 1; awready = 1; wready = 1; cy("cc_send", 9'b000010110); nx();
      clr(); rvalid = 1; rid = 0; rdata = 32'hCAFEF00D; cy("cc_r", 9'b010001001);
      chk("cc_irdata", 64'(inst_sram_rdata), 64'(32'hCAFEF00D)); nx();
      clr(); bvalid = 1; cy("cc_b", 9'b000100001); nx();
      clr(); cy("cc_idle", 9'b000000000); nx();

      // Reset asserted while in R_DATA
      clr(); inst_sram_req = 1; inst_sram_addr = 32'h1C000020; cy("rs_iacc", 9'b100000000); nx();
      clr(); arready = 1; cy("rs_ar", 9'b000010000); nx();
      clr(); cy("rs_rdata_wait", 9'b000001000); nx();
      clr(); reset = 1; nx();
      reset = 0;
      clr(); rvalid = 1; rid = 0; rdata = 32'h11111111; cy("rs_after", 9'b000000000);
      chk("rs_ar_cleared", 64'({arid, araddr, arsize}), 64'(0)); nx();
      clr(); inst_sram_req = 1; inst_sram_addr = 32'h1C000024; cy("rs_idle_accept", 9'b100000000); nx();
      clr(); nx();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
